// File: rtl/mult_pkg.sv
// ============================================================================
// mult_pkg: shared types and helpers for the seq_mult shift-add multiplier | Rev 1.0
// ============================================================================
`default_nettype none

package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step counter must be able to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sign_mag_conv.sv
// ============================================================================
// sign_mag_conv: two's-complement to sign/magnitude, with an extra forced negate | Rev 1.0
// ============================================================================
`default_nettype none

module sign_mag_conv
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] value,
  input  logic             is_signed,
  input  logic             force_neg,
  output logic [WIDTH-1:0] magnitude,
  output logic             sign
);

  assign sign = is_signed & value[WIDTH-1];

  // The most-negative input maps onto itself, which is the correct unsigned magnitude.
  assign magnitude = (sign ^ force_neg) ? (~value + WIDTH'(1)) : value;

endmodule

`default_nettype wire

// File: rtl/seq_mult.sv
// ============================================================================
// seq_mult: WIDTH-cycle shift-add multiplier, unsigned or signed per operation | Rev 1.0
// ============================================================================
`default_nettype none

module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int                CNT_W     = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(WIDTH - 1);

  state_e                state_q, state_d;
  logic [2*WIDTH-1:0]    acc_q, acc_d;
  logic [2*WIDTH-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0]      mcand_q, mcand_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  neg_q, neg_d;

  logic [WIDTH-1:0]      a_mag, b_mag;
  logic                  a_sign, b_sign;
  logic [WIDTH:0]        step_sum;
  logic [2*WIDTH-1:0]    step_acc;
  logic [2*WIDTH-1:0]    prod_cond;
  logic                  unused_prod_sign;

  sign_mag_conv #(.WIDTH(WIDTH)) u_conv_a (
    .value     (a),
    .is_signed (signed_mode),
    .force_neg (1'b0),
    .magnitude (a_mag),
    .sign      (a_sign)
  );

  sign_mag_conv #(.WIDTH(WIDTH)) u_conv_b (
    .value     (b),
    .is_signed (signed_mode),
    .force_neg (1'b0),
    .magnitude (b_mag),
    .sign      (b_sign)
  );

  // Multiplier occupies the low half of the accumulator and is consumed as it shifts out.
  assign step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign step_acc = {step_sum, acc_q[WIDTH-1:1]};

  sign_mag_conv #(.WIDTH(2*WIDTH)) u_conv_prod (
    .value     (step_acc),
    .is_signed (1'b0),
    .force_neg (neg_q),
    .magnitude (prod_cond),
    .sign      (unused_prod_sign)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d = a_mag;
          acc_d   = {{WIDTH{1'b0}}, b_mag};
          neg_d   = a_sign ^ b_sign;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          prod_d  = prod_cond;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign prod = prod_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_mult.sv
// ============================================================================
// tb_seq_mult: randomized + directed self-checking bench for seq_mult | Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_mult;

  localparam int W = 8;

  logic           clk;
  logic           reset;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   a, b;
  logic           busy, done;
  logic [2*W-1:0] prod;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  seq_mult #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .prod        (prod)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    longint xv, yv, p;
    xv = s ? longint'($signed(x)) : longint'(x);
    yv = s ? longint'($signed(y)) : longint'(y);
    p  = xv * yv;
    return p[2*W-1:0];
  endfunction

  // Reference: an accepted request yields its product exactly W edges later.
  bit             m_run  = 1'b0;
  bit             m_done = 1'b0;
  logic [2*W-1:0] m_prod = '0;
  logic [2*W-1:0] m_pending = '0;
  int             m_left = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_run  = 1'b0;
      m_done = 1'b0;
      m_prod = '0;
      m_left = 0;
    end else if (m_run) begin
      m_left--;
      if (m_left == 0) begin
        m_run  = 1'b0;
        m_done = 1'b1;
        m_prod = m_pending;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_pending = ref_mul(a, b, signed_mode);
        m_run     = 1'b1;
        m_left    = W;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", busy, m_run);
      chk("model_done", done, m_done);
      chk("model_prod", prod, m_prod);
    end
  end

  task automatic wait_done(output int t);
    t = -1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done) begin
        t = cyc;
        break;
      end
      a = W'($urandom);
      b = W'($urandom);
      signed_mode = 1'($urandom);
    end
    if (t < 0) chk("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input logic [2*W-1:0] lit, input string nm);
    int t0, t;
    @(negedge clk);
    a = x; b = y; signed_mode = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    wait_done(t);
    chk({nm, "_latency"}, 64'(t - t0), 64'(W));
    chk({nm, "_prod"}, prod, lit);
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = 8'h80;
      1:       v = 8'h7F;
      2:       v = 8'hFF;
      3:       v = 8'h00;
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    int t0, t1, t2;
    bit seen;
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 64'd0);
    chk("reset_done", done, 64'd0);
    chk("reset_prod", prod, 64'd0);
    reset = 1'b0;

    run_one(8'd255, 8'd255, 1'b0, 16'hFE01, "u255x255");
    @(negedge clk);
    chk("idle_after_done", busy, 64'd0);
    run_one(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_m3x5");
    run_one(8'h80, 8'h80, 1'b1, 16'h4000, "s_minxmin");
    run_one(8'h80, 8'h7F, 1'b1, 16'hC080, "s_minxmax");
    run_one(8'hF0, 8'h00, 1'b1, 16'h0000, "s_negx0");

    // Back-to-back with start held high; operands scrambled while running.
    @(negedge clk);
    a = 8'd7; b = 8'd9; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    wait_done(t1);
    chk("b2b_first_latency", 64'(t1 - t0), 64'(W));
    chk("b2b_first_prod", prod, 64'd63);
    a = 8'd12; b = 8'd12; signed_mode = 1'b0;
    wait_done(t2);
    start = 1'b0;
    chk("b2b_spacing", 64'(t2 - t1), 64'(W + 1));
    chk("b2b_second_prod", prod, 64'd144);

    // start during RUN is ignored.
    @(negedge clk);
    a = 8'd20; b = 8'd11; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    repeat (2) @(negedge clk);
    a = 8'd3; b = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(t1);
    chk("ign_start_latency", 64'(t1 - t0), 64'(W));
    chk("ign_start_prod", prod, 64'd220);

    // Reset mid-run aborts the operation.
    @(negedge clk);
    a = 8'd100; b = 8'd100; signed_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 64'd0);
    chk("abort_done", done, 64'd0);
    chk("abort_prod", prod, 64'd0);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", seen, 64'd0);
    run_one(8'd13, 8'd11, 1'b0, 16'd143, "after_abort");

    // Randomized traffic, including held start and occasional resets.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      start       = ($urandom_range(0, 2) != 0);
      a           = pick_operand();
      b           = pick_operand();
      signed_mode = 1'($urandom);
      reset       = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
